segment_sequencer: RTL and testbench

Parametrised segment/index sequencer that generalises the two-segment modulation and STM settings (per-segment cycle, repeat count, requested read segment) to `NUM_SEGMENTS` segments. It adds selectable transition modes: immediate, index-wrap-synchronous, system-time and GPIO-triggered. It sits between the settings/controller block and the modulation/STM memory readers. It drives the active segment and the read index for one sample stream.

---
 rtl/segment_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_segment_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_sequencer.sv
// segment_sequencer
// Drives the active segment and the read index for one sample stream. It
// generalises the two-segment modulation/STM settings to NUM_SEGMENTS segments.
// Each segment has its own last valid index (CYCLE) and a loop count (REP).
// Segment changes are requested with UPDATE and use one of four transition
// modes: immediate, index-wrap-synchronous, system-time and GPIO-triggered.
//
// Ports:
//   CLK, RST_N        system clock, asynchronous active-low reset
//   UPDATE            one-cycle pulse latching REQ_SEGMENT/TRANSITION_MODE/
//                     TRANSITION_VALUE/REP
//   REQ_SEGMENT       requested segment
//   TRANSITION_MODE   0 immediate, 1 sync-to-wrap, 2 system time, 3 GPIO
//   TRANSITION_VALUE  target system time for mode 2
//   REP               loop count of the new segment (0 = once, all-ones = forever)
//   CYCLE             last valid index per segment, segment k at [k*CYCLE_W +: CYCLE_W]
//   TICK              sample-advance strobe
//   SYS_TIME          synchronised system time
//   GPIO_IN           asynchronous trigger input
//   SEGMENT, IDX      active segment and read index
//   PENDING           a transition is waiting for its condition
//   STOP              loop count exhausted, index frozen
//
// Configuration macro: SEGMENT_SEQ_GPIO_TRIGGER_EN adds the GPIO transition
// mode with its synchroniser and edge detector. Without the macro, an UPDATE
// with mode 3 is ignored and GPIO_IN is unused.

module segment_sequencer #(
    parameter int NUM_SEGMENTS = 4,
    parameter int SEG_W        = $clog2(NUM_SEGMENTS),
    parameter int CYCLE_W      = 16,
    parameter int REP_W        = 32
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            UPDATE,
    input  logic [SEG_W-1:0]                REQ_SEGMENT,
    input  logic [1:0]                      TRANSITION_MODE,
    input  logic [63:0]                     TRANSITION_VALUE,
    input  logic [REP_W-1:0]                REP,
    input  logic [NUM_SEGMENTS*CYCLE_W-1:0] CYCLE,
    input  logic                            TICK,
    input  logic [63:0]                     SYS_TIME,
    input  logic                            GPIO_IN,
    output logic [SEG_W-1:0]                SEGMENT,
    output logic [CYCLE_W-1:0]              IDX,
    output logic                            PENDING,
    output logic                            STOP
);

    localparam logic [1:0] MODE_IMMEDIATE = 2'd0;
    localparam logic [1:0] MODE_SYNC_IDX  = 2'd1;
    localparam logic [1:0] MODE_SYS_TIME  = 2'd2;
    localparam logic [1:0] MODE_GPIO      = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_STOPPED
    } state_t;

    state_t             state;
    logic               update_q;
    logic [SEG_W-1:0]   req_seg_q;
    logic [1:0]         mode_q;
    logic [63:0]        value_q;
    logic [REP_W-1:0]   rep_q;
    logic [REP_W-1:0]   rep_cnt;
    logic               tick_q;
    logic               time_ok;
    logic               gpio_rise;
    logic               mode_ok;
    logic               update_valid;
    logic [CYCLE_W-1:0] cycle_cur;
    logic               wrap;
    logic               cond_met;
    logic               do_switch;

`ifdef SEGMENT_SEQ_GPIO_TRIGGER_EN
    logic gpio_s1;
    logic gpio_s2;
    logic gpio_s3;

    // Two-flop synchroniser followed by a registered rising-edge detector.
    // A level held high produces a single pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gpio_s1   <= 1'b0;
            gpio_s2   <= 1'b0;
            gpio_s3   <= 1'b0;
            gpio_rise <= 1'b0;
        end else begin
            gpio_s1   <= GPIO_IN;
            gpio_s2   <= gpio_s1;
            gpio_s3   <= gpio_s2;
            gpio_rise <= gpio_s2 & ~gpio_s3;
        end
    end

    assign mode_ok = 1'b1;
`else
    logic unused_gpio;

    assign unused_gpio = GPIO_IN;
    assign gpio_rise   = 1'b0;
    assign mode_ok     = (TRANSITION_MODE != MODE_GPIO);
`endif

    // Out-of-range segments (and GPIO mode when it is not built) are dropped
    // before anything is latched, so the existing request survives.
    assign update_valid = UPDATE && (int'(REQ_SEGMENT) < NUM_SEGMENTS) && mode_ok;

    assign cycle_cur = CYCLE[int'(SEGMENT)*CYCLE_W +: CYCLE_W];
    // ">=" rather than "==" so that an index stranded above a shrunken CYCLE wraps.
    assign wrap      = (IDX >= cycle_cur);

    // Input stage: request latch, tick and time comparison are all registered,
    // so every decision in the main FSM is one edge behind its inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            update_q  <= 1'b0;
            req_seg_q <= '0;
            mode_q    <= MODE_IMMEDIATE;
            value_q   <= '0;
            rep_q     <= '1;
            tick_q    <= 1'b0;
            time_ok   <= 1'b0;
        end else begin
            update_q <= update_valid;
            tick_q   <= TICK;
            time_ok  <= (SYS_TIME >= value_q);
            if (update_valid) begin
                req_seg_q <= REQ_SEGMENT;
                mode_q    <= TRANSITION_MODE;
                value_q   <= TRANSITION_VALUE;
                rep_q     <= REP;
            end
        end
    end

    // Transition condition for the pending request. A stopped stream
    // has nothing left to wrap, so sync mode then takes the next tick.
    always_comb begin
        cond_met = 1'b0;
        case (mode_q)
            MODE_SYNC_IDX: cond_met = tick_q && (STOP || wrap);
            MODE_SYS_TIME: cond_met = time_ok;
            MODE_GPIO:     cond_met = gpio_rise;
            default:       cond_met = 1'b0;
        endcase
    end

    // A fresh update outranks an old pending condition. An immediate update
    // also outranks a coincident tick.
    assign do_switch = update_q ? (mode_q == MODE_IMMEDIATE)
                                : ((state == ST_WAIT) && cond_met);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_RUN;
            SEGMENT <= '0;
            IDX     <= '0;
            PENDING <= 1'b0;
            STOP    <= 1'b0;
            rep_cnt <= '1;
        end else if (do_switch) begin
            state   <= ST_RUN;
            SEGMENT <= req_seg_q;
            IDX     <= '0;
            rep_cnt <= rep_q;
            STOP    <= 1'b0;
            PENDING <= 1'b0;
        end else begin
            if (update_q) begin
                state   <= ST_WAIT;
                PENDING <= 1'b1;
            end
            if (tick_q && !STOP) begin
                if (wrap) begin
                    if (rep_cnt == '0) begin
                        STOP <= 1'b1;
                        IDX  <= cycle_cur;
                        if (!update_q && state == ST_RUN) begin
                            state <= ST_STOPPED;
                        end
                    end else begin
                        IDX <= '0;
                        if (rep_cnt != '1) begin
                            rep_cnt <= rep_cnt - REP_W'(1);
                        end
                    end
                end else begin
                    IDX <= IDX + CYCLE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_segment_sequencer.sv
// tb_segment_sequencer
// Testbench for segment_sequencer. Uses NUM_SEGMENTS = 4 with a widened
// SEG_W = 3, so that a request for segment 4 can actually be expressed.
// A table of per-cycle vectors covers the tick/loop/stop behaviour. Separate
// hand-written sequences cover the multi-cycle transition modes, the async
// reset and a shrinking CYCLE.

module tb_segment_sequencer;

    localparam int NUM_SEGMENTS = 4;
    localparam int SEG_W        = 3;
    localparam int CYCLE_W      = 16;
    localparam int REP_W        = 32;

`ifdef SEGMENT_SEQ_GPIO_TRIGGER_EN
    localparam bit GpioEn = 1'b1;
`else
    localparam bit GpioEn = 1'b0;
`endif

    logic                            CLK;
    logic                            RST_N;
    logic                            UPDATE;
    logic [SEG_W-1:0]                REQ_SEGMENT;
    logic [1:0]                      TRANSITION_MODE;
    logic [63:0]                     TRANSITION_VALUE;
    logic [REP_W-1:0]                REP;
    logic [NUM_SEGMENTS*CYCLE_W-1:0] CYCLE;
    logic                            TICK;
    logic [63:0]                     SYS_TIME;
    logic                            GPIO_IN;
    logic [SEG_W-1:0]                SEGMENT;
    logic [CYCLE_W-1:0]              IDX;
    logic                            PENDING;
    logic                            STOP;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic             tick;
        logic             upd;
        logic [SEG_W-1:0] seg;
        logic [1:0]       mode;
        logic [REP_W-1:0] rep;
        logic [SEG_W-1:0] expSeg;
        logic [15:0]      expIdx;
        logic             expPend;
        logic             expStop;
    } vec_t;

    vec_t vecQ[$];

    segment_sequencer #(
        .NUM_SEGMENTS (NUM_SEGMENTS),
        .SEG_W        (SEG_W),
        .CYCLE_W      (CYCLE_W),
        .REP_W        (REP_W)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .UPDATE           (UPDATE),
        .REQ_SEGMENT      (REQ_SEGMENT),
        .TRANSITION_MODE  (TRANSITION_MODE),
        .TRANSITION_VALUE (TRANSITION_VALUE),
        .REP              (REP),
        .CYCLE            (CYCLE),
        .TICK             (TICK),
        .SYS_TIME         (SYS_TIME),
        .GPIO_IN          (GPIO_IN),
        .SEGMENT          (SEGMENT),
        .IDX              (IDX),
        .PENDING          (PENDING),
        .STOP             (STOP)
    );

    // Free-running 10 ns clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance n rising edges and settle 1 ns past the last one
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Compare all four outputs against the expected values as one check
    task automatic checkOutput(input string name, input logic [SEG_W-1:0] eSeg,
                               input logic [15:0] eIdx, input logic ePend, input logic eStop);
        assertCount++;
        if (SEGMENT !== eSeg || IDX !== eIdx || PENDING !== ePend || STOP !== eStop) begin
            failCount++;
            $display("[TB] FAIL %s: got seg=%0d idx=%0d pend=%0d stop=%0d, expected seg=%0d idx=%0d pend=%0d stop=%0d",
                     name, SEGMENT, IDX, PENDING, STOP, eSeg, eIdx, ePend, eStop);
        end
    endtask

    // Compare a single integer measurement, such as an edge number
    task automatic checkValue(input string name, input int act, input int exp);
        assertCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input logic tick, input logic upd, input logic [SEG_W-1:0] seg,
                          input logic [1:0] mode, input logic [REP_W-1:0] rep,
                          input logic [SEG_W-1:0] eSeg, input logic [15:0] eIdx,
                          input logic ePend, input logic eStop);
        vec_t v;
        v.tick = tick; v.upd = upd; v.seg = seg; v.mode = mode; v.rep = rep;
        v.expSeg = eSeg; v.expIdx = eIdx; v.expPend = ePend; v.expStop = eStop;
        vecQ.push_back(v);
    endtask

    // Drive one vector and check the outputs one edge later
    task automatic applyStimulus(input vec_t v, input int row);
        TICK            = v.tick;
        UPDATE          = v.upd;
        REQ_SEGMENT     = v.seg;
        TRANSITION_MODE = v.mode;
        REP             = v.rep;
        cyc(1);
        checkOutput($sformatf("vec%0d", row), v.expSeg, v.expIdx, v.expPend, v.expStop);
    endtask

    // One isolated tick; IDX reflects it after the second edge
    task automatic tickOnce();
        TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        cyc(1);
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        cyc(2);
        checkOutput("reset", 0, 0, 0, 0);
        RST_N = 1'b1;
    endtask

    task automatic sendUpdate(input logic [SEG_W-1:0] seg, input logic [1:0] mode,
                              input logic [63:0] value);
        UPDATE           = 1'b1;
        REQ_SEGMENT      = seg;
        TRANSITION_MODE  = mode;
        TRANSITION_VALUE = value;
        REP              = '1;
        cyc(1);
        UPDATE = 1'b0;
    endtask

    // Main sequence
    initial begin
        int switchEdge;
        int pendAt1;

        RST_N = 1'b0; UPDATE = 1'b0; REQ_SEGMENT = '0; TRANSITION_MODE = 2'd0;
        TRANSITION_VALUE = '0; REP = '1; TICK = 1'b0; SYS_TIME = 64'd0; GPIO_IN = 1'b0;
        CYCLE = {16'd5, 16'd3, 16'd3, 16'd2};

        // Index loop on segment 0, then REP=1 on segment 2 until STOP,
        // then an immediate update colliding with a tick, then an invalid segment
        addVec(1, 0, 0, 0, '1, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, '1, 0, 1, 0, 0);
        addVec(1, 0, 0, 0, '1, 0, 2, 0, 0);
        addVec(1, 0, 0, 0, '1, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, '1, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, '1, 0, 2, 0, 0);
        addVec(0, 1, 2, 0, 1,  0, 2, 0, 0);
        addVec(0, 0, 0, 0, '1, 2, 0, 0, 0);
        addVec(1, 0, 0, 0, '1, 2, 0, 0, 0);
        addVec(1, 0, 0, 0, '1, 2, 1, 0, 0);
        addVec(1, 0, 0, 0, '1, 2, 2, 0, 0);
        addVec(1, 0, 0, 0, '1, 2, 3, 0, 0);
        addVec(1, 0, 0, 0, '1, 2, 0, 0, 0);
        addVec(1, 0, 0, 0, '1, 2, 1, 0, 0);
        addVec(1, 0, 0, 0, '1, 2, 2, 0, 0);
        addVec(1, 0, 0, 0, '1, 2, 3, 0, 0);
        addVec(1, 0, 0, 0, '1, 2, 3, 0, 1);
        addVec(1, 0, 0, 0, '1, 2, 3, 0, 1);
        addVec(0, 0, 0, 0, '1, 2, 3, 0, 1);
        addVec(0, 0, 0, 0, '1, 2, 3, 0, 1);
        addVec(1, 1, 0, 0, '1, 2, 3, 0, 1);
        addVec(0, 0, 0, 0, '1, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, '1, 0, 0, 0, 0);
        addVec(0, 1, 4, 0, '1, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, '1, 0, 0, 0, 0);

        cyc(1);
        doReset();
        foreach (vecQ[i]) applyStimulus(vecQ[i], i);

        // Sync-to-wrap: request issued at IDX=1 of a 0..3 loop
        doReset();
        CYCLE[15:0] = 16'd3;
        tickOnce();
        sendUpdate(1, 2'd1, 64'd0);
        cyc(1);
        checkOutput("sync_pending", 0, 1, 1, 0);
        tickOnce();
        tickOnce();
        checkOutput("sync_at_last", 0, 3, 1, 0);
        tickOnce();
        checkOutput("sync_switch", 1, 0, 0, 0);

        // System time ramping from 990, target 1000
        switchEdge = -1;
        for (int k = 0; k < 15; k++) begin
            SYS_TIME         = 64'd990 + 64'(k);
            UPDATE           = (k == 0);
            REQ_SEGMENT      = 3'd2;
            TRANSITION_MODE  = 2'd2;
            TRANSITION_VALUE = 64'd1000;
            cyc(1);
            if (k == 1) checkOutput("systime_pending", 1, 0, 1, 0);
            if (switchEdge < 0 && SEGMENT == 3'd2) switchEdge = k;
        end
        UPDATE = 1'b0;
        checkValue("systime_ramp_edge", switchEdge, 11);

        // System time already past target: switch two edges after UPDATE
        switchEdge = -1;
        for (int k = 0; k < 5; k++) begin
            UPDATE           = (k == 0);
            REQ_SEGMENT      = 3'd1;
            TRANSITION_MODE  = 2'd2;
            TRANSITION_VALUE = 64'd500;
            cyc(1);
            if (switchEdge < 0 && SEGMENT == 3'd1) switchEdge = k;
        end
        UPDATE = 1'b0;
        checkValue("systime_past_edge", switchEdge, 2);

        // GPIO trigger to segment 3, input rises before edge 20 and stays high
        switchEdge = -1;
        pendAt1    = 0;
        for (int c = 0; c < 31; c++) begin
            UPDATE          = (c == 0);
            REQ_SEGMENT     = 3'd3;
            TRANSITION_MODE = 2'd3;
            GPIO_IN         = (c >= 20);
            cyc(1);
            if (c == 1) pendAt1 = int'(PENDING);
            if (switchEdge < 0 && SEGMENT == 3'd3) switchEdge = c;
        end
        UPDATE = 1'b0;
        checkValue("gpio_pending", pendAt1, GpioEn ? 1 : 0);
        checkValue("gpio_edge", switchEdge, GpioEn ? 23 : -1);
        checkOutput("gpio_final", GpioEn ? 3'd3 : 3'd1, 0, 0, 0);
        GPIO_IN = 1'b0;

        // Async reset while a request is waiting on an unreachable time
        sendUpdate(2, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1);
        checkOutput("wait_before_reset", GpioEn ? 3'd3 : 3'd1, 0, 1, 0);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0);
        cyc(1);
        RST_N = 1'b1;
        cyc(1);

        // CYCLE shrinks below the current index: the next tick wraps
        CYCLE[15:0] = 16'd3;
        tickOnce();
        tickOnce();
        tickOnce();
        checkOutput("shrink_before", 0, 3, 0, 0);
        CYCLE[15:0] = 16'd1;
        tickOnce();
        checkOutput("shrink_wrap", 0, 0, 0, 0);
        tickOnce();
        checkOutput("shrink_after", 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
